tile_feed_sequencer: RTL

TILE_FEED_SEQUENCER -- requirements
Module: tile_feed_sequencer

---
 rtl/tile_feed_sequencer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/tile_feed_sequencer.sv
// Tile feed sequencer: issues A-row / B-column bank reads for one 4x4 output
// tile and skews the returned data onto the west/north edges of a 4x4 array.
module tile_feed_sequencer #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  input  logic [4:0]           i_n,
  input  logic [1:0]           i_ti,
  input  logic [1:0]           i_tj,
  input  logic [AW-1:0]        i_a_base,
  input  logic [AW-1:0]        i_b_base,
  input  logic                 i_abort,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err,
  output logic                 o_a_rd_en,
  output logic                 o_b_rd_en,
  output logic [AW-1:0]        o_a_addr   [0:3],
  output logic [AW-1:0]        o_b_addr   [0:3],
  input  logic signed [DW-1:0] i_a_dout   [0:3],
  input  logic signed [DW-1:0] i_b_dout   [0:3],
  output logic signed [DW-1:0] o_west_in  [0:3],
  output logic signed [DW-1:0] o_north_in [0:3],
  output logic [3:0]           o_west_vld,
  output logic [3:0]           o_north_vld,
  output logic                 o_acc_clr
);

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_ISSUE, S_FLUSH, S_DONE} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [4:0]    r_n;
  logic [4:0]    r_k;
  logic [1:0]    r_ti;
  logic [1:0]    r_tj;
  logic [AW-1:0] r_a_base;
  logic [AW-1:0] r_b_base;
  logic          r_err;
  logic          r_rd_d;
  logic          w_cmd_ok;
  logic          w_cmd_seen;
  logic          w_accept;
  logic          w_last_k;
  logic          w_flush_end;

  always_comb begin
    w_cmd_ok = 1'b0;
    case (i_n)
      5'd4:    w_cmd_ok = (i_ti == 2'd0) && (i_tj == 2'd0);
      5'd8:    w_cmd_ok = (i_ti < 2'd2) && (i_tj < 2'd2);
      5'd16:   w_cmd_ok = 1'b1;
      default: w_cmd_ok = 1'b0;
    endcase
  end

  // abort beats start in IDLE: the command is dropped without err
  assign w_cmd_seen  = (r_state == S_IDLE) && i_start && !i_abort;
  assign w_accept    = w_cmd_seen && w_cmd_ok;
  assign w_last_k    = (r_k == r_n - 5'd1);
  assign w_flush_end = (r_k == 5'd4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (i_abort && (r_state != S_IDLE)) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_accept) w_state_next = S_CLR;
        S_CLR:   w_state_next = S_ISSUE;
        S_ISSUE: if (w_last_k) w_state_next = S_FLUSH;
        S_FLUSH: if (w_flush_end) w_state_next = S_DONE;
        S_DONE:  w_state_next = S_IDLE;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    o_busy    = (r_state != S_IDLE);
    o_done    = (r_state == S_DONE);
    o_acc_clr = (r_state == S_CLR);
    o_a_rd_en = (r_state == S_ISSUE);
    o_b_rd_en = (r_state == S_ISSUE);
    o_err     = r_err;
    for (int r = 0; r < 4; r++) begin
      o_a_addr[r] = '0;
      o_b_addr[r] = '0;
      if (r_state == S_ISSUE) begin
        o_a_addr[r] = r_a_base + (AW'({r_ti, 2'b00}) + AW'(r)) * AW'(r_n) + AW'(r_k);
        o_b_addr[r] = r_b_base + AW'(r_k) * AW'(r_n) + AW'({r_tj, 2'b00}) + AW'(r);
      end
    end
  end

  // k restarts on every state change and doubles as the flush counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n      <= '0;
      r_k      <= '0;
      r_ti     <= '0;
      r_tj     <= '0;
      r_a_base <= '0;
      r_b_base <= '0;
      r_err    <= 1'b0;
      r_rd_d   <= 1'b0;
    end else begin
      r_err  <= w_cmd_seen && !w_cmd_ok;
      r_rd_d <= o_a_rd_en && !i_abort;
      if (w_accept) begin
        r_n      <= i_n;
        r_ti     <= i_ti;
        r_tj     <= i_tj;
        r_a_base <= i_a_base;
        r_b_base <= i_b_base;
      end
      if (w_state_next != r_state) begin
        r_k <= '0;
      end else if ((r_state == S_ISSUE) || (r_state == S_FLUSH)) begin
        r_k <= r_k + 5'd1;
      end else begin
        r_k <= '0;
      end
    end
  end

  // lane gi: capture stage plus gi delay stages; data forced to 0 when not valid
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic signed [DW-1:0] r_w_sr [0:gi];
      logic signed [DW-1:0] r_n_sr [0:gi];
      logic [gi:0]          r_w_sv;
      logic [gi:0]          r_n_sv;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_w_sv <= '0;
          r_n_sv <= '0;
          for (int s = 0; s <= gi; s++) begin
            r_w_sr[s] <= '0;
            r_n_sr[s] <= '0;
          end
        end else if (i_abort) begin
          r_w_sv <= '0;
          r_n_sv <= '0;
          for (int s = 0; s <= gi; s++) begin
            r_w_sr[s] <= '0;
            r_n_sr[s] <= '0;
          end
        end else begin
          r_w_sv[0] <= r_rd_d;
          r_n_sv[0] <= r_rd_d;
          r_w_sr[0] <= r_rd_d ? i_a_dout[gi] : '0;
          r_n_sr[0] <= r_rd_d ? i_b_dout[gi] : '0;
          for (int s = 1; s <= gi; s++) begin
            r_w_sv[s] <= r_w_sv[s-1];
            r_n_sv[s] <= r_n_sv[s-1];
            r_w_sr[s] <= r_w_sr[s-1];
            r_n_sr[s] <= r_n_sr[s-1];
          end
        end
      end

      assign o_west_in[gi]   = r_w_sr[gi];
      assign o_north_in[gi]  = r_n_sr[gi];
      assign o_west_vld[gi]  = r_w_sv[gi];
      assign o_north_vld[gi] = r_n_sv[gi];
    end
  endgenerate

endmodule
